pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//   Shares one physical-memory port between the instruction cache (port A) and the
//   data cache (port B). Sits directly downstream of both caches' pmem interfaces
//   and upstream of the cacheline adapter / physical memory.
//   Serves one line-sized read or write at a time, with round-robin or fixed
//   priority arbitration.
// PARAMETERS
//   ADDR_WIDTH  32   physical address width
//   LINE_WIDTH  256  cacheline width in bits
//   RR_EN       1    1: round-robin on simultaneous requests; 0: port B always wins
// PORTS
//   clk           in   1           system clock, all state updates on rising edge
//   rst           in   1           asynchronous, active-high reset
//   pmem_read_a   in   1           I-cache line read request (held until pmem_resp_a)
//   pmem_addr_a   in   ADDR_WIDTH  I-cache line address
//   pmem_rdata_a  out  LINE_WIDTH  line data to I-cache
//   pmem_resp_a   out  1           I-cache transaction done
//   pmem_read_b   in   1           D-cache line read request
//   pmem_write_b  in   1           D-cache line write-back request
//   pmem_addr_b   in   ADDR_WIDTH  D-cache line address
//   pmem_wdata_b  in   LINE_WIDTH  D-cache write-back data
//   pmem_rdata_b  out  LINE_WIDTH  line data to D-cache
//   pmem_resp_b   out  1           D-cache transaction done
//   mem_read      out  1           read request to memory (registered)
//   mem_write     out  1           write request to memory (registered)
//   mem_address   out  ADDR_WIDTH  latched request address (registered)
//   mem_wdata     out  LINE_WIDTH  latched write data (registered)
//   mem_rdata     in   LINE_WIDTH  memory read data, valid with mem_resp
//   mem_resp      in   1           memory transaction complete (single-cycle pulse)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE.
//     - All outputs 0: mem_read, mem_write, mem_address, mem_wdata, both resp.
//     - last_grant=B, so port A wins the first tie.
//   Reset mid-transaction aborts it immediately: mem_read/mem_write drop
//   asynchronously and no resp is issued.
//   States: IDLE, SERVE_A, SERVE_B.
//   IDLE:
//     - reqA = pmem_read_a; reqB = pmem_read_b | pmem_write_b.
//     - Only one request: grant it. Both: RR_EN=1 grants the port != last_grant;
//       RR_EN=0 grants B.
//     - On grant, latch at the same edge: address, wdata (B only), rw type.
//       B with read and write both high is treated as a write.
//     - Set mem_read or mem_write, update last_grant, go to SERVE_x.
//   Latency: request sampled at edge N -> mem_read/mem_write high from edge N onward.
//     Those outputs are visible in cycle N+1.
//   SERVE_x:
//     - mem_* outputs come from the latched registers and do not follow the
//       cache inputs.
//     - A requester dropping its request early does not abort the transaction.
//     - On mem_resp=1, combinationally: pmem_resp_x=1 and pmem_rdata_x=mem_rdata.
//       The other port's resp stays 0.
//     - Same edge: clear mem_read/mem_write and go to IDLE.
//   Mandatory one IDLE cycle between transactions; the cache deasserts its request
//   in that cycle.
//   pmem_rdata_a/b = mem_rdata at all times. Only resp qualifies the data.
//   mem_resp while in IDLE is ignored: no resp is forwarded and no state change.
//   No address/data arithmetic; widths pass through unchanged.
// TESTING
//   1. I-only: read_a=1, addr_a=0x0000_1000
//      -> mem_read=1, mem_address=0x1000 next cycle.
//      mem_resp with rdata=0xDEAD..BEEF -> resp_a=1 same cycle with that data;
//      resp_b=0.
//   2. D write-back: write_b=1, addr_b=0x0000_2020, wdata_b=256'hA5..A5
//      -> mem_write=1 with latched addr/data.
//      Change the inputs mid-transaction -> mem_* unchanged until mem_resp.
//   3. Tie, RR_EN=1, out of reset: A and B request together -> A served first,
//      one IDLE cycle, then B. Repeat the tie -> A then B again, alternating.
//   4. RR_EN=0: simultaneous requests from A and B three times in a row -> B
//      granted every time.
//   5. Assert rst while in SERVE_B with mem_write=1 -> mem_write drops before the
//      next edge, state IDLE, no resp. A later mem_resp in IDLE is ignored.
//   6. read_b and write_b both high -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between the I-cache (port A)
// and the D-cache (port B). It serves one line-sized transaction at a time.
// The memory-side request, address and write data are registered and are
// latched on the grant edge, so they ignore the cache inputs during a transaction.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  // port A: instruction cache
  input  logic                  pmem_read_a,
  input  logic [ADDR_WIDTH-1:0] pmem_addr_a,
  output logic [LINE_WIDTH-1:0] pmem_rdata_a,
  output logic                  pmem_resp_a,
  // port B: data cache
  input  logic                  pmem_read_b,
  input  logic                  pmem_write_b,
  input  logic [ADDR_WIDTH-1:0] pmem_addr_b,
  input  logic [LINE_WIDTH-1:0] pmem_wdata_b,
  output logic [LINE_WIDTH-1:0] pmem_rdata_b,
  output logic                  pmem_resp_b,
  // memory side
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_A = 2'd1;
  localparam logic [1:0] SERVE_B = 2'd2;

  // last_grant: 1'b1 = port B was served last, 1'b0 = port A
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [1:0] state;
  logic       last_grant;
  logic       req_a;
  logic       req_b;
  logic       grant_a;
  logic       grant_b;

  // Grant decision for the IDLE state: single requester wins outright; on a tie
  // round-robin picks the port not served last, fixed priority always picks B.
  always_comb begin
    req_a   = pmem_read_a;
    req_b   = pmem_read_b | pmem_write_b;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      if (RR_EN && (last_grant == GRANT_B)) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end else if (req_a) begin
      grant_a = 1'b1;
    end else if (req_b) begin
      grant_b = 1'b1;
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  // Transaction FSM: latch the granted request, hold it until mem_resp, then
  // return to IDLE (giving the mandatory idle cycle between transactions).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_B;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= {ADDR_WIDTH{1'b0}};
      mem_wdata   <= {LINE_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (grant_a) begin
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= pmem_addr_a;
            last_grant  <= GRANT_A;
            state       <= SERVE_A;
          end else if (grant_b) begin
            // a simultaneous read and write from the D-cache is a write-back
            mem_read    <= ~pmem_write_b;
            mem_write   <= pmem_write_b;
            mem_address <= pmem_addr_b;
            mem_wdata   <= pmem_wdata_b;
            last_grant  <= GRANT_B;
            state       <= SERVE_B;
          end else begin
            state <= IDLE;
          end
        end
        SERVE_A, SERVE_B: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= state;
          end
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Read data is broadcast to both caches; only the resp strobe qualifies it.
  assign pmem_rdata_a = mem_rdata;
  assign pmem_rdata_b = mem_rdata;
  assign pmem_resp_a  = (state == SERVE_A) && mem_resp;
  assign pmem_resp_b  = (state == SERVE_B) && mem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter: a vector table for the basic transaction
// flow plus hand-written sequences for arbitration and reset corner cases.
module tb_pmem_arbiter;

  logic         clk;
  logic         rst;
  logic         read_a, read_b, write_b, mem_resp;
  logic [31:0]  addr_a, addr_b;
  logic [255:0] wdata_b, mem_rdata;

  logic [255:0] rr_rdata_a, rr_rdata_b, rr_mwdata;
  logic         rr_resp_a, rr_resp_b, rr_mread, rr_mwrite;
  logic [31:0]  rr_maddr;
  logic [255:0] fp_rdata_a, fp_rdata_b, fp_mwdata;
  logic         fp_resp_a, fp_resp_b, fp_mread, fp_mwrite;
  logic [31:0]  fp_maddr;

  int checks = 0;
  int errors = 0;

  pmem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .pmem_read_a(read_a), .pmem_addr_a(addr_a),
    .pmem_rdata_a(rr_rdata_a), .pmem_resp_a(rr_resp_a),
    .pmem_read_b(read_b), .pmem_write_b(write_b), .pmem_addr_b(addr_b),
    .pmem_wdata_b(wdata_b), .pmem_rdata_b(rr_rdata_b), .pmem_resp_b(rr_resp_b),
    .mem_read(rr_mread), .mem_write(rr_mwrite), .mem_address(rr_maddr),
    .mem_wdata(rr_mwdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  pmem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .pmem_read_a(read_a), .pmem_addr_a(addr_a),
    .pmem_rdata_a(fp_rdata_a), .pmem_resp_a(fp_resp_a),
    .pmem_read_b(read_b), .pmem_write_b(write_b), .pmem_addr_b(addr_b),
    .pmem_wdata_b(wdata_b), .pmem_rdata_b(fp_rdata_b), .pmem_resp_b(fp_resp_b),
    .mem_read(fp_mread), .mem_write(fp_mwrite), .mem_address(fp_maddr),
    .mem_wdata(fp_mwdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ra, rb, wb;
    logic [31:0]  aa, ab;
    logic [255:0] wd;
    logic         resp;
    logic [255:0] rd;
    logic         e_rd, e_wr;
    logic [31:0]  e_addr;
    logic [255:0] e_wd;
    logic         e_ra, e_rb;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic ra, input logic rb, input logic wb,
                              input logic [31:0] aa, input logic [31:0] ab,
                              input logic [255:0] wd, input logic resp,
                              input logic [255:0] rd, input logic e_rd,
                              input logic e_wr, input logic [31:0] e_addr,
                              input logic [255:0] e_wd, input logic e_ra,
                              input logic e_rb);
    vec_t v;
    v.ra = ra; v.rb = rb; v.wb = wb; v.aa = aa; v.ab = ab; v.wd = wd;
    v.resp = resp; v.rd = rd; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wd = e_wd; v.e_ra = e_ra; v.e_rb = e_rb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read_a = 1'b0; read_b = 1'b0; write_b = 1'b0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  logic [255:0] dead_beef, pat_a5, pat_5a, z256;

  initial begin
    dead_beef = {16'hDEAD, 224'h0, 16'hBEEF};
    pat_a5    = {32{8'hA5}};
    pat_5a    = {32{8'h5A}};
    z256      = 256'h0;
    rst = 1'b1;
    idle_inputs();
    addr_a = 32'h0; addr_b = 32'h0; wdata_b = 256'h0; mem_rdata = 256'h0;

    //                ra    rb    wb    addr_a        addr_b        wdata_b       resp  mem_rdata          e_rd  e_wr  e_addr        e_wdata             e_ra  e_rb
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0,        z256,          1'b0, z256,              1'b0, 1'b0, 32'h0,        z256,               1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0,        z256,          1'b0, z256,              1'b1, 1'b0, 32'h0000_1000, z256,              1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0,        z256,          1'b1, dead_beef,         1'b1, 1'b0, 32'h0000_1000, z256,              1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        z256,          1'b0, z256,              1'b0, 1'b0, 32'h0000_1000, z256,              1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_2020, pat_a5,       1'b0, z256,              1'b0, 1'b0, 32'h0000_1000, z256,              1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_7000, 32'hFFFF_0000, pat_5a,       1'b0, z256,              1'b0, 1'b1, 32'h0000_2020, pat_a5,            1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 32'h0000_7000, 32'hFFFF_0000, pat_5a,       1'b1, pat_5a,            1'b0, 1'b1, 32'h0000_2020, pat_a5,            1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        z256,          1'b0, z256,              1'b0, 1'b0, 32'h0000_2020, pat_a5,            1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_3000, 256'h1234,    1'b0, z256,              1'b0, 1'b0, 32'h0000_2020, pat_a5,            1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_3000, 256'h1234,    1'b0, z256,              1'b0, 1'b1, 32'h0000_3000, 256'h1234,         1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_3000, 256'h1234,    1'b1, 256'h77,           1'b0, 1'b1, 32'h0000_3000, 256'h1234,         1'b0, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        z256,          1'b1, 256'h99,           1'b0, 1'b0, 32'h0000_3000, 256'h1234,         1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        z256,          1'b0, z256,              1'b0, 1'b0, 32'h0000_3000, 256'h1234,         1'b0, 1'b0);

    // reset values while rst is held
    #12;
    chk("rst_mem_read",  {255'h0, rr_mread},  256'h0);
    chk("rst_mem_write", {255'h0, rr_mwrite}, 256'h0);
    chk("rst_mem_addr",  {224'h0, rr_maddr},  256'h0);
    chk("rst_mem_wdata", rr_mwdata,           256'h0);
    chk("rst_resp_a",    {255'h0, rr_resp_a}, 256'h0);
    chk("rst_resp_b",    {255'h0, rr_resp_b}, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // table: basic I-read, D write-back with input changes, read+write, idle resp
    for (int i = 0; i < 13; i++) begin
      read_a = vecs[i].ra; read_b = vecs[i].rb; write_b = vecs[i].wb;
      addr_a = vecs[i].aa; addr_b = vecs[i].ab; wdata_b = vecs[i].wd;
      mem_resp = vecs[i].resp; mem_rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_mem_read", i),  {255'h0, rr_mread},  {255'h0, vecs[i].e_rd});
      chk($sformatf("v%0d_mem_write", i), {255'h0, rr_mwrite}, {255'h0, vecs[i].e_wr});
      chk($sformatf("v%0d_mem_addr", i),  {224'h0, rr_maddr},  {224'h0, vecs[i].e_addr});
      chk($sformatf("v%0d_mem_wdata", i), rr_mwdata,           vecs[i].e_wd);
      chk($sformatf("v%0d_resp_a", i),    {255'h0, rr_resp_a}, {255'h0, vecs[i].e_ra});
      chk($sformatf("v%0d_resp_b", i),    {255'h0, rr_resp_b}, {255'h0, vecs[i].e_rb});
      chk($sformatf("v%0d_rdata_a", i),   rr_rdata_a,          vecs[i].rd);
      chk($sformatf("v%0d_rdata_b", i),   rr_rdata_b,          vecs[i].rd);
      step();
    end

    // round-robin ties out of reset: A then B, twice
    do_reset();
    addr_a = 32'h0000_00A0; addr_b = 32'h0000_00B0; mem_rdata = 256'h5;
    for (int r = 0; r < 2; r++) begin
      read_a = 1'b1; read_b = 1'b1;
      step();
      chk($sformatf("rr%0d_first_addr", r), {224'h0, rr_maddr}, {224'h0, 32'h0000_00A0});
      chk($sformatf("rr%0d_first_read", r), {255'h0, rr_mread}, 256'h1);
      mem_resp = 1'b1; #1;
      chk($sformatf("rr%0d_resp_a", r), {254'h0, rr_resp_a, rr_resp_b}, 256'h2);
      step();
      read_a = 1'b0; mem_resp = 1'b0; #1;
      chk($sformatf("rr%0d_idle", r), {255'h0, rr_mread}, 256'h0);
      step();
      chk($sformatf("rr%0d_second_addr", r), {224'h0, rr_maddr}, {224'h0, 32'h0000_00B0});
      chk($sformatf("rr%0d_second_read", r), {255'h0, rr_mread}, 256'h1);
      mem_resp = 1'b1; #1;
      chk($sformatf("rr%0d_resp_b", r), {254'h0, rr_resp_a, rr_resp_b}, 256'h1);
      step();
      read_b = 1'b0; mem_resp = 1'b0;
      step();
    end

    // fixed priority: B wins three ties in a row
    do_reset();
    for (int r = 0; r < 3; r++) begin
      read_a = 1'b1; read_b = 1'b1;
      step();
      chk($sformatf("fp%0d_addr", r), {224'h0, fp_maddr}, {224'h0, 32'h0000_00B0});
      mem_resp = 1'b1; #1;
      chk($sformatf("fp%0d_resp", r), {254'h0, fp_resp_a, fp_resp_b}, 256'h1);
      step();
      idle_inputs();
      step();
    end

    // async reset in SERVE_B aborts the write, later idle resp is ignored
    do_reset();
    write_b = 1'b1; addr_b = 32'h0000_4000; wdata_b = pat_a5;
    step();
    chk("ar_mem_write_before", {255'h0, rr_mwrite}, 256'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_mem_write_drop", {255'h0, rr_mwrite}, 256'h0);
    mem_resp = 1'b1; #1;
    chk("ar_no_resp", {254'h0, rr_resp_a, rr_resp_b}, 256'h0);
    @(negedge clk);
    write_b = 1'b0;
    rst = 1'b0;
    #1;
    chk("ar_idle_resp_ignored", {254'h0, rr_resp_a, rr_resp_b}, 256'h0);
    step();
    chk("ar_stays_idle", {254'h0, rr_mread, rr_mwrite}, 256'h0);
    mem_resp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
